pmu_sleep_ctrl: RTL and testbench
=================================

Name: pmu_sleep_ctrl

Overview:
Parametrised power management unit that gates the high-frequency oscillator (HFOSC) on and off.
- Sleep is requested when the core writes a configured sentinel value to the stack-pointer observation bus (rdsp) and holds it for an idle window.
- Wake-up is driven by any of N maskable wake requests.
- Sits beside the core in sail-core, clocked from an always-running clock, and drives the HFOSC primitive's enable and powerup pins.

Parameters:
DATA_WIDTH, 32, width of rdsp.
SLEEP_SP, 32'h1000, rdsp value that requests sleep.
IDLE_CYCLES, 16, consecutive matching cycles required before sleep; 0 means sleep on first match.
WAKE_DELAY, 8, cycles of powerup-only settle before enable returns; minimum 1.
NUM_WAKE, 4, number of wake request lines; minimum 1.
MAX_SLEEPS, 0, number of sleep entries allowed; 0 means unlimited.
CNT_W, 8, width of sleep_count.

Ports:
fast_clk  input  1  free-running clock, never gated by this block; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
rdsp  input  DATA_WIDTH  stack-pointer observation bus.
wake_req  input  NUM_WAKE  level wake requests, synchronous to fast_clk.
wake_mask  input  NUM_WAKE  1 = line enabled for wake.
clkhf_enable  output  1  HFOSC enable, registered.
clkhf_powerup  output  1  HFOSC powerup, registered.
sleeping  output  1  high in SLEEP state only.
wake_src  output  NUM_WAKE  masked wake_req captured at the last wake.
sleep_count  output  CNT_W  saturating count of sleep entries.

Behaviour:
- Reset (async assert, any state) immediately sets:
  - state ACTIVE; enable=1, powerup=1, sleeping=0.
  - wake_src=0, sleep_count=0, idle/wake counters=0, armed=1.
- wake = |(wake_req & wake_mask). match = (rdsp==SLEEP_SP). budget_ok = (MAX_SLEEPS==0) or (sleep_count<MAX_SLEEPS).
- ACTIVE (enable=1, powerup=1):
  - armed clears on wake exit and sets on any cycle with !match.
  - match & armed & budget_ok & !wake: if IDLE_CYCLES==0, go to EN_OFF; otherwise go to DRAIN with counter=IDLE_CYCLES-1.
- DRAIN (outputs as ACTIVE):
  - !match or wake: go to ACTIVE (abort; sleep_count unchanged).
  - Counter==0: go to EN_OFF.
  - Otherwise decrement the counter.
  - Time from first match cycle to enable falling = IDLE_CYCLES+1 edges.
- EN_OFF (enable=0, powerup=1), exactly one cycle:
  - wake: go to ACTIVE; powerup never dropped, no count.
  - Otherwise go to SLEEP; sleep_count += 1, saturating at all-ones.
- SLEEP (enable=0, powerup=0, sleeping=1):
  - rdsp ignored.
  - wake: capture wake_src = wake_req & wake_mask; go to POWERUP with counter=WAKE_DELAY-1.
- POWERUP (enable=0, powerup=1):
  - Decrement the counter; at 0 go to ACTIVE with armed=0.
  - wake_req changes are ignored; rdsp is ignored.
- Ordering: enable always falls one cycle before powerup falls, and powerup always rises WAKE_DELAY cycles before enable rises. The two signals never change in the same cycle except at reset.
- Budget exhausted: the block stays in ACTIVE permanently until reset. With MAX_SLEEPS=1 and no wake lines enabled, the block goes to sleep once and stays asleep, matching first-generation one-shot behaviour.
- Masking wake lines while in SLEEP is legal. If all lines are masked, the block stays asleep until reset.
- Width rules:
  - Counters are sized $clog2(max(IDLE_CYCLES,WAKE_DELAY)+1).
  - sleep_count never wraps.
- All outputs are driven directly from flops; no combinational path from input to output.

Test Plan:
1. Reset/idle: assert rst_n=0, then release with rdsp=0 for 50 cycles -> enable=1, powerup=1, sleeping=0, sleep_count=0 throughout.
2. Sleep entry (defaults): hold rdsp=32'h1000 -> enable falls 17 edges after the first match, powerup falls 1 cycle later, sleeping=1, sleep_count=1.
3. Abort: rdsp=32'h1000 for 10 cycles, then 32'h0FFC -> enable never falls, sleep_count=0; re-match 16+ cycles -> sleeps.
4. Wake: in SLEEP, wake_mask=4'b0101, pulse wake_req=4'b0010 -> no wake; then wake_req=4'b0100 -> powerup=1 next cycle, enable=1 8 cycles later, wake_src=4'b0100. With rdsp still 32'h1000 -> no re-sleep until rdsp leaves and returns.
5. Budget: MAX_SLEEPS=2, three sleep/wake sequences -> third match is ignored, sleep_count=2. CNT_W=2 with unlimited sleeps -> sleep_count saturates at 3.
6. Async reset mid-SLEEP and mid-POWERUP -> enable=1, powerup=1, sleeping=0 without waiting for a clock edge; wake_src and sleep_count return to 0.

Source files
------------

// File: rtl/pmu_sleep_ctrl.sv
// pmu_sleep_ctrl
// Gates the high-frequency oscillator (HFOSC) around core sleep periods.
// The core requests sleep by parking its stack pointer at SLEEP_SP.
// Once rdsp has held that value for an idle window, the block first drops
// clkhf_enable and then clkhf_powerup. Any enabled wake line brings the
// oscillator back. Powerup rises first, and enable follows once the
// oscillator has had WAKE_DELAY cycles to settle.
//
// Ports
//   fast_clk       free-running clock, never gated by this block
//   rst_n          asynchronous active-low reset
//   rdsp           stack-pointer observation bus
//   wake_req       level wake requests, synchronous to fast_clk
//   wake_mask      1 = wake line enabled
//   clkhf_enable   HFOSC enable (registered)
//   clkhf_powerup  HFOSC powerup (registered)
//   sleeping       high only while fully asleep
//   wake_src       masked wake requests captured at the most recent wake
//   sleep_count    saturating count of sleep entries
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACTIVE  | oscillator fully on, watching rdsp for the sleep sentinel
// DRAIN   | sentinel seen, counting down the idle window
// EN_OFF  | enable dropped, powerup still high (one cycle)
// SLEEP   | enable and powerup both low, waiting for a wake request
// POWERUP | powerup high, enable held low while the oscillator settles

module pmu_sleep_ctrl #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] SLEEP_SP    = DATA_WIDTH'(32'h1000),
    parameter int                    IDLE_CYCLES = 16,
    parameter int                    WAKE_DELAY  = 8,
    parameter int                    NUM_WAKE    = 4,
    parameter int                    MAX_SLEEPS  = 0,
    parameter int                    CNT_W       = 8
) (
    input  logic                  fast_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rdsp,
    input  logic [NUM_WAKE-1:0]   wake_req,
    input  logic [NUM_WAKE-1:0]   wake_mask,
    output logic                  clkhf_enable,
    output logic                  clkhf_powerup,
    output logic                  sleeping,
    output logic [NUM_WAKE-1:0]   wake_src,
    output logic [CNT_W-1:0]      sleep_count
);

    localparam int CNT_MAX  = (IDLE_CYCLES > WAKE_DELAY) ? IDLE_CYCLES : WAKE_DELAY;
    localparam int CW_RAW   = $clog2(CNT_MAX + 1);
    localparam int CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int IDLE_M1  = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
    localparam int WAKE_M1  = (WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0;
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_M1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_M1);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_EN_OFF  = 3'd2,
        ST_SLEEP   = 3'd3,
        ST_POWERUP = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          armed;

    logic wake;
    logic match;
    logic budget_ok;

    assign wake      = |(wake_req & wake_mask);
    assign match     = (rdsp == SLEEP_SP);
    assign budget_ok = (MAX_SLEEPS == 0) || (32'(sleep_count) < MAX_SLEEPS);

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_ACTIVE;
            clkhf_enable  <= 1'b1;
            clkhf_powerup <= 1'b1;
            sleeping      <= 1'b0;
            wake_src      <= '0;
            sleep_count   <= '0;
            cnt           <= '0;
            armed         <= 1'b1;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    // After a wake the core may still be parked at the
                    // sentinel; it has to leave it once before we re-arm.
                    if (!match)
                        armed <= 1'b1;
                    if (match && armed && budget_ok && !wake) begin
                        if (IDLE_CYCLES == 0) begin
                            state        <= ST_EN_OFF;
                            clkhf_enable <= 1'b0;
                        end else begin
                            state <= ST_DRAIN;
                            cnt   <= IDLE_LOAD;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (!match || wake) begin
                        state <= ST_ACTIVE;
                    end else if (cnt == '0) begin
                        state        <= ST_EN_OFF;
                        clkhf_enable <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_EN_OFF: begin
                    if (wake) begin
                        // Powerup never dropped, so re-enable at once.
                        state        <= ST_ACTIVE;
                        clkhf_enable <= 1'b1;
                    end else begin
                        state         <= ST_SLEEP;
                        clkhf_powerup <= 1'b0;
                        sleeping      <= 1'b1;
                        if (sleep_count != {CNT_W{1'b1}})
                            sleep_count <= sleep_count + 1'b1;
                    end
                end

                ST_SLEEP: begin
                    if (wake) begin
                        wake_src      <= wake_req & wake_mask;
                        state         <= ST_POWERUP;
                        clkhf_powerup <= 1'b1;
                        sleeping      <= 1'b0;
                        cnt           <= WAKE_LOAD;
                    end
                end

                ST_POWERUP: begin
                    if (cnt == '0) begin
                        state        <= ST_ACTIVE;
                        clkhf_enable <= 1'b1;
                        armed        <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state         <= ST_ACTIVE;
                    clkhf_enable  <= 1'b1;
                    clkhf_powerup <= 1'b1;
                    sleeping      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmu_sleep_ctrl.sv
// Testbench for pmu_sleep_ctrl. Three differently parameterised instances
// share one stimulus stream:
//   inst 0: defaults (idle 16, wake delay 8, unlimited sleeps, 8-bit count)
//   inst 1: idle 3, wake delay 2, at most 2 sleeps
//   inst 2: idle 0, wake delay 1, unlimited sleeps, 2-bit count
module tb_pmu_sleep_ctrl;

    logic        fast_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] rdsp     = 32'h0;
    logic [3:0]  wake_req = 4'h0;
    logic [3:0]  wake_mask = 4'h0;

    logic        en  [3];
    logic        pu  [3];
    logic        slp [3];
    logic [3:0]  src [3];
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
    logic [1:0]  cnt_c;

    int total = 0;
    int bad   = 0;

    always #5 fast_clk = ~fast_clk;

    pmu_sleep_ctrl u_a (
        .fast_clk(fast_clk), .rst_n(rst_n), .rdsp(rdsp),
        .wake_req(wake_req), .wake_mask(wake_mask),
        .clkhf_enable(en[0]), .clkhf_powerup(pu[0]), .sleeping(slp[0]),
        .wake_src(src[0]), .sleep_count(cnt_a)
    );

    pmu_sleep_ctrl #(.IDLE_CYCLES(3), .WAKE_DELAY(2), .MAX_SLEEPS(2)) u_b (
        .fast_clk(fast_clk), .rst_n(rst_n), .rdsp(rdsp),
        .wake_req(wake_req), .wake_mask(wake_mask),
        .clkhf_enable(en[1]), .clkhf_powerup(pu[1]), .sleeping(slp[1]),
        .wake_src(src[1]), .sleep_count(cnt_b)
    );

    pmu_sleep_ctrl #(.IDLE_CYCLES(0), .WAKE_DELAY(1), .CNT_W(2)) u_c (
        .fast_clk(fast_clk), .rst_n(rst_n), .rdsp(rdsp),
        .wake_req(wake_req), .wake_mask(wake_mask),
        .clkhf_enable(en[2]), .clkhf_powerup(pu[2]), .sleeping(slp[2]),
        .wake_src(src[2]), .sleep_count(cnt_c)
    );

    // ---------------- behavioural model ----------------
    int p_idle [3] = '{16, 3, 0};
    int p_wake [3] = '{8, 2, 1};
    int p_max  [3] = '{0, 2, 0};
    int p_cmax [3] = '{255, 255, 3};

    // run: matching edges seen in the current idle window (0 = none pending)
    // wt : powerup settle edges still to go (0 = not settling)
    int m_en [3], m_pu [3], m_slp [3], m_src [3], m_cnt [3];
    int m_run [3], m_arm [3], m_wt [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_en[i] = 1; m_pu[i] = 1; m_slp[i] = 0; m_src[i] = 0; m_cnt[i] = 0;
            m_run[i] = 0; m_arm[i] = 1; m_wt[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic [31:0] sp, logic [3:0] rq, logic [3:0] mk);
        bit w;
        bit mt;
        bit budget;
        w  = |(rq & mk);
        mt = (sp == 32'h1000);
        if (m_slp[i] == 1) begin
            if (w) begin
                m_slp[i] = 0; m_pu[i] = 1; m_src[i] = int'(rq & mk); m_wt[i] = p_wake[i];
            end
        end else if (m_wt[i] > 0) begin
            m_wt[i]--;
            if (m_wt[i] == 0) begin
                m_en[i] = 1; m_arm[i] = 0;
            end
        end else if (m_en[i] == 0) begin
            if (w) m_en[i] = 1;
            else begin
                m_pu[i] = 0; m_slp[i] = 1;
                if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
            end
        end else if (m_run[i] > 0) begin
            if (!mt || w) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] > p_idle[i]) begin m_en[i] = 0; m_run[i] = 0; end
            end
        end else begin
            budget = (p_max[i] == 0) || (m_cnt[i] < p_max[i]);
            if (mt && m_arm[i] == 1 && budget && !w) begin
                m_run[i] = 1;
                if (m_run[i] > p_idle[i]) begin m_en[i] = 0; m_run[i] = 0; end
            end
            if (!mt) m_arm[i] = 1;
        end
    endtask

    always @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int i = 0; i < 3; i++) model_step(i, rdsp, wake_req, wake_mask);
    end

    // ---------------- checking ----------------
    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge fast_clk) begin
        if (rst_n) begin
            int dc [3];
            dc[0] = int'(cnt_a); dc[1] = int'(cnt_b); dc[2] = int'(cnt_c);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_en%0d", i),  int'(en[i]),  m_en[i]);
                check($sformatf("model_pu%0d", i),  int'(pu[i]),  m_pu[i]);
                check($sformatf("model_slp%0d", i), int'(slp[i]), m_slp[i]);
                check($sformatf("model_src%0d", i), int'(src[i]), m_src[i]);
                check($sformatf("model_cnt%0d", i), dc[i],        m_cnt[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge fast_clk);
            #2;
        end
    endtask

    task automatic async_reset();
        @(posedge fast_clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_en", int'(en[0]), 1);
        check("rst_pu", int'(pu[0]), 1);
        check("rst_slp", int'(slp[0]), 0);
        check("rst_src", int'(src[0]), 0);
        check("rst_cnt", int'(cnt_a), 0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        step(1);

        // idle after reset
        rdsp = 32'h0;
        step(50);
        check("idle_en", int'(en[0]), 1);
        check("idle_pu", int'(pu[0]), 1);
        check("idle_cnt", int'(cnt_a), 0);

        // sleep entry: enable falls 17 edges after first match
        rdsp = 32'h1000;
        n = 0;
        while (en[0] == 1'b1 && n < 40) begin step(1); n++; end
        check("entry_edges", n, 17);
        check("entry_pu_hold", int'(pu[0]), 1);
        step(1);
        check("entry_pu_low", int'(pu[0]), 0);
        check("entry_slp", int'(slp[0]), 1);
        check("entry_cnt", int'(cnt_a), 1);

        // masked line does not wake; enabled line does
        wake_mask = 4'b0101;
        wake_req  = 4'b0010;
        step(3);
        check("masked_slp", int'(slp[0]), 1);
        wake_req = 4'b0100;
        step(1);
        check("wake_pu", int'(pu[0]), 1);
        check("wake_en", int'(en[0]), 0);
        check("wake_src", int'(src[0]), 4);
        n = 0;
        while (en[0] == 1'b0 && n < 40) begin step(1); n++; end
        check("wake_edges", n, 8);
        wake_req = 4'b0000;
        step(40);
        check("no_resleep_en", int'(en[0]), 1);
        check("no_resleep_cnt", int'(cnt_a), 1);

        // abort inside the idle window, then a full window sleeps
        rdsp = 32'h0; step(2);
        rdsp = 32'h1000; step(10);
        rdsp = 32'h0FFC; step(10);
        check("abort_en", int'(en[0]), 1);
        check("abort_cnt", int'(cnt_a), 1);
        rdsp = 32'h1000; step(20);
        check("rematch_slp", int'(slp[0]), 1);
        check("rematch_cnt", int'(cnt_a), 2);

        // async reset while asleep
        async_reset();
        step(1);

        // async reset while settling
        wake_mask = 4'b1111;
        rdsp = 32'h0; step(2);
        rdsp = 32'h1000; step(20);
        wake_req = 4'b0001; step(1);
        wake_req = 4'b0000; step(3);
        check("pwrup_en", int'(en[0]), 0);
        check("pwrup_pu", int'(pu[0]), 1);
        async_reset();
        step(1);

        // budget limit on inst 1, saturation on inst 2
        rdsp = 32'h0; step(2);
        for (int it = 0; it < 4; it++) begin
            rdsp = 32'h1000; step(30);
            if (it == 2) check("budget_en", int'(en[1]), 1);
            wake_req = 4'b0001; step(2);
            wake_req = 4'b0000;
            rdsp = 32'h0; step(20);
        end
        check("budget_cnt", int'(cnt_b), 2);
        check("sat_cnt", int'(cnt_c), 3);
        check("loop_cnt", int'(cnt_a), 4);

        // randomized segments against the model
        async_reset();
        step(1);
        for (int seg = 0; seg < 150; seg++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 40));
            if (kind < 2)       rdsp = 32'h1000;
            else if (kind == 2) rdsp = 32'h0FFC;
            else                rdsp = $urandom;
            if ($urandom_range(0, 9) == 0) wake_mask = 4'($urandom);
            for (int c = 0; c < len; c++) begin
                wake_req = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
                step(1);
            end
            if (seg == 75) begin
                async_reset();
                step(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
